// File: rtl/obj_fetch_pkg.sv
// Shared types and constants for the object fetch engine.
// Optional feature macro: OBJ_FETCH_CGB_EN (3-bit palette, VRAM bank select).
package obj_fetch_pkg;

  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] VRAM_BASE = 16'h8000;

`ifdef OBJ_FETCH_CGB_EN
  localparam int unsigned PAL_W = 3;
`else
  localparam int unsigned PAL_W = 1;
`endif

  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [5:0] oam_idx;
    logic [3:0] row;
  } obj_slot_t;

  typedef struct packed {
    logic [1:0]       color;
    logic [PAL_W-1:0] pal;
    logic             prio;
  } obj_pix_t;

  typedef enum logic [2:0] {
    IDLE,
    FLAGS,
    TILE,
    LO,
    HI,
    MERGE
  } fetch_state_e;

  // Row within the tile after optional vertical flip.
  function automatic logic [3:0] eff_row(input logic [3:0] row,
                                         input logic       flip_y,
                                         input logic       tall);
    if (!flip_y) return row;
    return tall ? (4'd15 - row) : (4'd7 - row);
  endfunction

endpackage

// File: rtl/obj_slot_matcher.sv
// Per-slot hit detector: slot X equals current pixel X + 8 (9-bit compare).
module obj_slot_matcher
  import obj_fetch_pkg::*;
#(
  parameter int unsigned XW = 8
) (
  input  logic            obj_ena_i,
  input  obj_slot_t       slot_i,
  input  logic            done_i,
  input  logic [XW-1:0]   x_i,
  output logic            hit_o
);

  // Combinational hit for one slot.
  always_comb begin
    hit_o = obj_ena_i && slot_i.valid && !done_i && (slot_i.x != 8'd0) &&
            ({1'b0, slot_i.x} == (9'(x_i) + 9'd8));
  end

endmodule

// File: rtl/obj_fetch_engine.sv
// Object fetch engine: fetches flags/tile/pattern bytes for the lowest-index
// hitting slot and merges the 8 pixels into the object FIFO.
// Optional feature macro: OBJ_FETCH_CGB_EN.
module obj_fetch_engine
  import obj_fetch_pkg::*;
#(
  parameter int unsigned SLOTS = 10,
  parameter int unsigned X_MAX = 160
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       tclk_in,
  input  logic                       line_start_in,
  input  logic [$clog2(X_MAX)-1:0]   X_in,
  input  logic                       tall_mode_in,
  input  logic                       obj_ena_in,
  input  obj_slot_t [SLOTS-1:0]      slots_in,
  output logic                       fetch_active_out,
  output logic                       mem_req_out,
  output logic [15:0]                mem_addr_out,
  input  logic                       mem_gnt_in,
  input  logic [7:0]                 mem_rdata_in,
  input  logic                       mem_rvalid_in,
  input  obj_pix_t [7:0]             fifo_in,
  output obj_pix_t [7:0]             fifo_out,
  output logic                       fifo_we_out
);

  localparam int unsigned SEL_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned XW    = $clog2(X_MAX);

  fetch_state_e      state_q;
  logic [SLOTS-1:0]  done_q;
  logic [SEL_W-1:0]  sel_q;
  logic [5:0]        oam_q;
  logic [3:0]        row_q;
  logic [7:0]        flags_q, tile_q, lo_q, hi_q;
  logic              wait_q;
  logic              mem_req_q;
  logic [15:0]       mem_addr_q;
  obj_pix_t [7:0]    fifo_q;
  logic              fifo_we_q;
  logic              active_q;

  logic [SLOTS-1:0]  hit;
  logic [SLOTS-1:0]  cand;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic [7:0]        tile_eff;
  logic [15:0]       lo_addr_d;
  obj_pix_t [7:0]    merged_d;
  obj_pix_t          npix;
  logic [2:0]        bsel;
  logic              unused_bits;

  for (genvar g = 0; g < SLOTS; g++) begin : g_match
    obj_slot_matcher #(.XW(XW)) u_match (
      .obj_ena_i (obj_ena_in),
      .slot_i    (slots_in[g]),
      .done_i    (done_q[g]),
      .x_i       (X_in),
      .hit_o     (hit[g])
    );
  end

  // Lowest-index hit; the slot being merged is excluded since its done mark lands this edge.
  always_comb begin
    cand = hit;
    if (state_q == MERGE) cand[sel_q] = 1'b0;
    pick_any = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (cand[i] && !pick_any) begin
        pick_any = 1'b1;
        pick_idx = SEL_W'(i);
      end
    end
  end

  // Pattern address from the returned tile number and effective row.
  always_comb begin
    tile_eff  = tall_mode_in ? {mem_rdata_in[7:1], 1'b0} : mem_rdata_in;
    lo_addr_d = VRAM_BASE + {4'h0, tile_eff, 4'h0} +
                {11'h0, eff_row(row_q, flags_q[6], tall_mode_in), 1'b0};
`ifdef OBJ_FETCH_CGB_EN
    lo_addr_d[13] = flags_q[3];
`endif
  end

  // New pixels overlay only transparent FIFO entries.
  always_comb begin
    merged_d = '0;
    npix     = '0;
    bsel     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bsel       = flags_q[5] ? 3'(i) : 3'(7 - i);
      npix.color = {hi_q[bsel], lo_q[bsel]};
`ifdef OBJ_FETCH_CGB_EN
      npix.pal   = flags_q[2:0];
`else
      npix.pal   = flags_q[4];
`endif
      npix.prio  = flags_q[7];
      merged_d[i] = (fifo_in[i].color == 2'b00) ? npix : fifo_in[i];
    end
  end

  // Fetch FSM with registered memory request and FIFO write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      done_q     <= '0;
      sel_q      <= '0;
      oam_q      <= '0;
      row_q      <= '0;
      flags_q    <= '0;
      tile_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      wait_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fifo_q     <= '0;
      fifo_we_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      fifo_we_q <= 1'b0;
      if (tclk_in) begin
        if (line_start_in) begin
          state_q   <= IDLE;
          done_q    <= '0;
          mem_req_q <= 1'b0;
          wait_q    <= 1'b0;
          active_q  <= 1'b0;
        end else begin
          if (mem_req_q && mem_gnt_in) begin
            mem_req_q <= 1'b0;
            wait_q    <= 1'b1;
          end
          case (state_q)
            FLAGS: if (wait_q && mem_rvalid_in) begin
              flags_q    <= mem_rdata_in;
              wait_q     <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= OAM_BASE + {8'h00, oam_q, 2'b10};
              state_q    <= TILE;
            end
            TILE: if (wait_q && mem_rvalid_in) begin
              tile_q     <= tile_eff;
              wait_q     <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= lo_addr_d;
              state_q    <= LO;
            end
            LO: if (wait_q && mem_rvalid_in) begin
              lo_q       <= mem_rdata_in;
              wait_q     <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= mem_addr_q + 16'd1;
              state_q    <= HI;
            end
            HI: if (wait_q && mem_rvalid_in) begin
              hi_q    <= mem_rdata_in;
              wait_q  <= 1'b0;
              state_q <= MERGE;
            end
            MERGE: begin
              fifo_q         <= merged_d;
              fifo_we_q      <= 1'b1;
              done_q[sel_q]  <= 1'b1;
              state_q        <= IDLE;
              active_q       <= 1'b0;
            end
            default: ;
          endcase
          // Start of a fetch is shared by IDLE and MERGE; overrides MERGE's return to IDLE.
          if ((state_q == IDLE || state_q == MERGE) && pick_any) begin
            sel_q      <= pick_idx;
            oam_q      <= slots_in[pick_idx].oam_idx;
            row_q      <= slots_in[pick_idx].row;
            mem_req_q  <= 1'b1;
            mem_addr_q <= OAM_BASE + {8'h00, slots_in[pick_idx].oam_idx, 2'b11};
            active_q   <= 1'b1;
            state_q    <= FLAGS;
          end
        end
      end
    end
  end

`ifdef OBJ_FETCH_CGB_EN
  assign unused_bits = ^{tile_q, flags_q[4]};
`else
  assign unused_bits = ^{tile_q, flags_q[3:0]};
`endif

  assign fetch_active_out = active_q;
  assign mem_req_out      = mem_req_q;
  assign mem_addr_out     = mem_addr_q;
  assign fifo_out         = fifo_q;
  assign fifo_we_out      = fifo_we_q;

endmodule

// File: tb/tb_obj_fetch_engine.sv
// Directed bench for obj_fetch_engine with a memory responder and scoreboards
// for request addresses and merged FIFO contents.
module tb_obj_fetch_engine;
  import obj_fetch_pkg::*;

  typedef obj_pix_t [7:0] fifo_t;

  logic              clk = 1'b0;
  logic              rst_in = 1'b1;
  logic              tclk_in = 1'b1;
  logic              line_start_in = 1'b0;
  logic [7:0]        X_in = '0;
  logic              tall_mode_in = 1'b0;
  logic              obj_ena_in = 1'b0;
  obj_slot_t [9:0]   slots = '0;
  logic              fetch_active_out;
  logic              mem_req_out;
  logic [15:0]       mem_addr_out;
  logic              mem_gnt_in = 1'b0;
  logic [7:0]        mem_rdata_in = '0;
  logic              mem_rvalid_in = 1'b0;
  fifo_t             fifo_in = '0;
  fifo_t             fifo_out;
  logic              fifo_we_out;

  int tests_run = 0;
  int fails = 0;
  int fifo_writes = 0;

  logic [15:0] exp_addr[$];
  fifo_t       exp_fifo[$];
  logic [7:0]  mem [logic [15:0]];

  logic        resp_pending = 1'b0;
  logic [7:0]  resp_data = '0;
  int          stall_cnt = 0;
  int          stall_len = 0;

  always #5 clk = ~clk;

  obj_fetch_engine #(.SLOTS(10), .X_MAX(160)) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .tclk_in          (tclk_in),
    .line_start_in    (line_start_in),
    .X_in             (X_in),
    .tall_mode_in     (tall_mode_in),
    .obj_ena_in       (obj_ena_in),
    .slots_in         (slots),
    .fetch_active_out (fetch_active_out),
    .mem_req_out      (mem_req_out),
    .mem_addr_out     (mem_addr_out),
    .mem_gnt_in       (mem_gnt_in),
    .mem_rdata_in     (mem_rdata_in),
    .mem_rvalid_in    (mem_rvalid_in),
    .fifo_in          (fifo_in),
    .fifo_out         (fifo_out),
    .fifo_we_out      (fifo_we_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic fifo_t mk_colors(input logic [15:0] cols);
    fifo_t r = '0;
    for (int i = 0; i < 8; i++) r[i].color = cols[2*i +: 2];
    return r;
  endfunction

  function automatic fifo_t merge_model(input logic [7:0] fl, input logic [7:0] lo,
                                        input logic [7:0] hi, input fifo_t fin);
    fifo_t    r;
    obj_pix_t p;
    int       b;
    for (int i = 0; i < 8; i++) begin
      b = fl[5] ? i : 7 - i;
      p = '0;
      p.color = {hi[b], lo[b]};
`ifdef OBJ_FETCH_CGB_EN
      p.pal = fl[2:0];
`else
      p.pal = fl[4];
`endif
      p.prio = fl[7];
      r[i] = (fin[i].color == 2'b00) ? p : fin[i];
    end
    return r;
  endfunction

  // Memory responder plus FIFO-write scoreboard, both sampled on the falling edge.
  always @(negedge clk) begin
    logic [15:0] ea;
    fifo_t       ef;
    mem_gnt_in    = 1'b0;
    mem_rvalid_in = 1'b0;
    if (resp_pending) begin
      mem_rvalid_in = 1'b1;
      mem_rdata_in  = resp_data;
      resp_pending  = 1'b0;
    end else if (mem_req_out) begin
      if (stall_cnt < stall_len) begin
        stall_cnt++;
      end else begin
        ea = (exp_addr.size() != 0) ? exp_addr.pop_front() : 16'hxxxx;
        check("mem_addr", mem_addr_out, ea);
        mem_gnt_in   = 1'b1;
        resp_data    = rd(mem_addr_out);
        resp_pending = 1'b1;
        stall_cnt    = 0;
        stall_len    = 0;
      end
    end
    if (fifo_we_out) begin
      fifo_writes++;
      ef = (exp_fifo.size() != 0) ? exp_fifo.pop_front() : 'x;
      check("fifo_out", fifo_out, ef);
    end
  end

  task automatic wait_done(input string tag);
    int c = 0;
    while (c < 400 && !(exp_fifo.size() == 0 && exp_addr.size() == 0 &&
                        !fetch_active_out && !mem_req_out)) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_fifo_drain"}, exp_fifo.size(), 0);
    check({tag, "_addr_drain"}, exp_addr.size(), 0);
  endtask

  task automatic wait_req(input logic [15:0] a, input string tag);
    logic seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (mem_req_out && mem_addr_out == a) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic next_line();
    slots = '0;
    line_start_in = 1'b1;
    @(negedge clk);
    line_start_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_basic();
    mem[16'hFE17] = 8'h00;
    mem[16'hFE16] = 8'h10;
    mem[16'h8104] = 8'hF0;
    mem[16'h8105] = 8'h0F;
    X_in = 8'd0;
    slots[0] = '{valid: 1'b1, x: 8'd8, oam_idx: 6'd5, row: 4'd2};
  endtask

  task automatic push_basic_addrs();
    exp_addr.push_back(16'hFE17);
    exp_addr.push_back(16'hFE16);
    exp_addr.push_back(16'h8104);
    exp_addr.push_back(16'h8105);
  endtask

  initial begin
    logic        gap;
    logic [15:0] held;
    int          w0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_active", fetch_active_out, 1'b0);
    check("rst_req", mem_req_out, 1'b0);
    check("rst_addr", mem_addr_out, 16'h0000);
    check("rst_we", fifo_we_out, 1'b0);
    check("rst_fifo", fifo_out, '0);
    rst_in = 1'b0;
    @(negedge clk);

    // Basic fetch; first blocked by obj_ena low, then by tclk low
    load_basic();
    push_basic_addrs();
    exp_fifo.push_back(mk_colors(16'hAA55));
    repeat (4) @(negedge clk);
    check("ena_block", fetch_active_out, 1'b0);
    obj_ena_in = 1'b1;
    tclk_in = 1'b0;
    repeat (4) @(negedge clk);
    check("tclk_gate_active", fetch_active_out, 1'b0);
    check("tclk_gate_req", mem_req_out, 1'b0);
    tclk_in = 1'b1;
    wait_done("basic");
    repeat (5) @(negedge clk);
    check("done_mark", fetch_active_out, 1'b0);
    next_line();

    // Tall mode, X/Y flip, odd tile number
    mem[16'hFE17] = 8'h60;
    mem[16'hFE16] = 8'h11;
    mem[16'h811A] = 8'hF0;
    mem[16'h811B] = 8'h0F;
    tall_mode_in = 1'b1;
    slots[0] = '{valid: 1'b1, x: 8'd8, oam_idx: 6'd5, row: 4'd2};
    exp_addr.push_back(16'hFE17);
    exp_addr.push_back(16'hFE16);
    exp_addr.push_back(16'h811A);
    exp_addr.push_back(16'h811B);
    exp_fifo.push_back(mk_colors(16'h55AA));
    wait_done("tall");
    tall_mode_in = 1'b0;
    next_line();

    // Two hits: slot1 before slot3, back-to-back, FIFO pixels preserved
    mem[16'hFE1F] = 8'h90;
    mem[16'hFE1E] = 8'h20;
    mem[16'h8202] = 8'hAA;
    mem[16'h8203] = 8'hCC;
    mem[16'hFE27] = 8'h00;
    mem[16'hFE26] = 8'h05;
    mem[16'h8050] = 8'hFF;
    mem[16'h8051] = 8'hFF;
    fifo_in[0] = '{color: 2'd3, pal: '0, prio: 1'b1};
    fifo_in[5] = '{color: 2'd1, pal: '1, prio: 1'b0};
    X_in = 8'd12;
    exp_addr.push_back(16'hFE1F);
    exp_addr.push_back(16'hFE1E);
    exp_addr.push_back(16'h8202);
    exp_addr.push_back(16'h8203);
    exp_addr.push_back(16'hFE27);
    exp_addr.push_back(16'hFE26);
    exp_addr.push_back(16'h8050);
    exp_addr.push_back(16'h8051);
    exp_fifo.push_back(merge_model(8'h90, 8'hAA, 8'hCC, fifo_in));
    exp_fifo.push_back(merge_model(8'h00, 8'hFF, 8'hFF, fifo_in));
    slots[3] = '{valid: 1'b1, x: 8'd20, oam_idx: 6'd9, row: 4'd0};
    slots[1] = '{valid: 1'b1, x: 8'd20, oam_idx: 6'd7, row: 4'd1};
    wait_req(16'hFE1F, "pair_start");
    gap = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (exp_fifo.size() == 0) break;
      if (!fetch_active_out && !fifo_we_out) gap = 1'b1;
    end
    check("active_continuous", gap, 1'b0);
    wait_done("pair");
    fifo_in = '0;
    next_line();

    // Grant held low for 5 clocks on the first request
    load_basic();
    stall_len = 5;
    push_basic_addrs();
    exp_fifo.push_back(mk_colors(16'hAA55));
    wait_req(16'hFE17, "stall_start");
    held = mem_addr_out;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_req", mem_req_out, 1'b1);
      check("stall_addr", mem_addr_out, held);
    end
    wait_done("stall");
    next_line();

    // line_start during HI aborts without a merge; slot fetches again
    load_basic();
    push_basic_addrs();
    push_basic_addrs();
    exp_fifo.push_back(mk_colors(16'hAA55));
    w0 = fifo_writes;
    wait_req(16'h8105, "abort_hi_seen");
    line_start_in = 1'b1;
    @(negedge clk);
    line_start_in = 1'b0;
    check("abort_idle", fetch_active_out, 1'b0);
    check("abort_no_we", fifo_we_out, 1'b0);
    wait_done("abort");
    check("abort_one_merge", fifo_writes - w0, 1);
    next_line();

    // Reset during TILE; the late rvalid must be ignored
    load_basic();
    exp_addr.push_back(16'hFE17);
    exp_addr.push_back(16'hFE16);
    push_basic_addrs();
    exp_fifo.push_back(mk_colors(16'hAA55));
    w0 = fifo_writes;
    wait_req(16'hFE16, "rst_tile_seen");
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    check("midrst_active", fetch_active_out, 1'b0);
    check("midrst_req", mem_req_out, 1'b0);
    check("midrst_addr", mem_addr_out, 16'h0000);
    check("midrst_we", fifo_we_out, 1'b0);
    check("midrst_fifo", fifo_out, '0);
    wait_done("midrst");
    check("midrst_one_merge", fifo_writes - w0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/obj_fetch_engine.md
OBJ_FETCH_ENGINE -- requirements
Module: obj_fetch_engine

Interface
REQ-001 SHALL have parameter SLOTS, default 10, meaning number of per-line object slots.
REQ-002 SHALL have parameter X_MAX, default 160, meaning visible pixels per line.
REQ-003 SHALL have port clk_in, input, 1, meaning the single system clock.
REQ-004 SHALL have port rst_in, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port tclk_in, input, 1, meaning T-cycle enable; all state advances only when high.
REQ-006 SHALL have port line_start_in, input, 1, meaning new scanline; clears all done marks.
REQ-007 SHALL have port X_in, input, $clog2(X_MAX), meaning current pixel X.
REQ-008 SHALL have port tall_mode_in, input, 1, meaning 8x16 object mode.
REQ-009 SHALL have port obj_ena_in, input, 1, meaning object rendering enabled.
REQ-010 SHALL have port slots_in, input, SLOTS x obj_slot_t, meaning slots {valid, X[7:0], oam_idx[5:0], row[3:0]} in OAM order.
REQ-011 SHALL have port fetch_active_out, output, 1, meaning the pixel pipeline must stall.
REQ-012 SHALL have ports mem_req_out (1), mem_addr_out (16), mem_gnt_in (1), mem_rdata_in (8), mem_rvalid_in (1), meaning the memory request/grant/return channel.
REQ-013 SHALL have ports fifo_in, input, 8 x obj_pix_t, and fifo_out, output, 8 x obj_pix_t, with obj_pix_t = {color[1:0], pal, prio}, meaning current and merged object FIFO contents.
REQ-014 SHALL have port fifo_we_out, output, 1, meaning fifo_out is to be written this clock.

Function
REQ-015 A slot SHALL hit when obj_ena_in && valid && !done && X != 0 && X == X_in + 8, compared at 9 bits.
REQ-016 Among hits, the lowest slot index SHALL be fetched first; remaining hits are fetched back-to-back.
REQ-017 The FSM SHALL have states IDLE, FLAGS, TILE, LO, HI, MERGE, each step advancing only on tclk_in.
REQ-018 Transitions SHALL be: IDLE->FLAGS on hit; FLAGS->TILE->LO->HI->MERGE, each on rvalid; MERGE->FLAGS if another hit exists, else IDLE.
REQ-019 fetch_active_out SHALL be high from the tclk of hit detection through MERGE, without dropping between back-to-back objects.
REQ-020 The FLAGS address SHALL be 0xFE00 + 4*oam_idx + 3; the TILE address SHALL be 0xFE00 + 4*oam_idx + 2.
REQ-021 The row SHALL be row, or (tall ? 15-row : 7-row) when flags[6] is set; in tall mode tile bit0 SHALL be cleared.
REQ-022 The LO address SHALL be 0x8000 + 16*tile + 2*row_eff; the HI address SHALL be the LO address + 1, in 16-bit arithmetic.
REQ-023 mem_req_out and mem_addr_out SHALL be held stable until mem_gnt_in; only one request SHALL be outstanding; data SHALL be captured on mem_rvalid_in.
REQ-024 In MERGE, fifo_we_out SHALL pulse for one clock; fifo_out[i] SHALL be the new pixel only where fifo_in[i].color == 0, otherwise fifo_in[i].
REQ-025 New pixel i SHALL be {HI[b], LO[b]}, with b = i when flags[5] is set, else b = 7-i; prio = flags[7].
REQ-026 The fetched slot SHALL be marked done in MERGE.
REQ-027 line_start_in SHALL abort any fetch to IDLE, suppress the merge, and clear done marks; a pending request SHALL be dropped and its rvalid ignored.
REQ-028 obj_ena_in low in IDLE SHALL block new fetches; a fetch already in progress SHALL complete.

Reset
REQ-029 On reset: state = IDLE, done marks = 0, mem_req_out = 0, mem_addr_out = 0, fifo_we_out = 0, fifo_out = all zero, fetch_active_out = 0, flags/tile/LO/HI registers = 0; a reset mid-fetch SHALL discard it.

Configuration
REQ-030 With OBJ_FETCH_CGB_EN defined: pal = flags[2:0] (obj_pix_t.pal is 3 bits), bit 13 of LO/HI addresses is replaced by flags[3], and priority is by slot index only.
REQ-031 Without OBJ_FETCH_CGB_EN: pal = flags[4] (1 bit) and VRAM bank 0 is used.

Structure
REQ-032 obj_fetch_pkg SHALL hold obj_slot_t, obj_pix_t, the FSM state enum, and the 0xFE00/0x8000 base constants.
REQ-033 A sub-module obj_slot_matcher SHALL compute the per-slot hit; it is instantiated SLOTS times.

Verification
REQ-034 Slot0 {X=8, oam 5, row 2}, X_in=0, flags 0x00, tile 0x10, LO=0xF0, HI=0x0F -> addresses 0xFE17, 0xFE16, 0x8104, 0x8105; fifo_out colors 1,1,1,1,2,2,2,2 (i=0..7).
REQ-035 Same stimulus with flags 0x60, tall mode, row 2 -> tile 0x10, LO address 0x811A, pixels reversed.
REQ-036 Slots 3 and 1 both at X=20, X_in=12 -> slot1 fetched first, then slot3; fetch_active_out continuously high; fifo_in non-zero pixels preserved.
REQ-037 mem_gnt_in held low for 5 clocks -> mem_addr_out stable and mem_req_out held throughout; no state advance.
REQ-038 line_start_in asserted during HI -> IDLE next tclk, no fifo_we_out pulse, the slot fetches again on the new line.
REQ-039 rst_in asserted mid-TILE -> all outputs at reset values on the next clock; a late rvalid is ignored.
